// File: rtl/pipe_ctrl_regs_pkg.sv
// Shared constants for the pipeline-register block: NOP encoding,
// forward-select codes and the layout of the decoded-control bundle.
package pipe_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int CTRL_W_DEF = 12;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Bit offsets of the fields inside CtrlD/CtrlE
    localparam int CTRL_REGWRITE   = 0;
    localparam int CTRL_RESSRC_LSB = 1;  // 2 bits
    localparam int CTRL_MEMWRITE   = 3;
    localparam int CTRL_JUMP       = 4;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_ALUCTL_LSB = 6;  // 3 bits
    localparam int CTRL_ALUSRC     = 9;  // bits 10..11 spare

    // The reserved code 2'b11 falls back to the register-file value
    function automatic logic [1:0] fwd_norm(input logic [1:0] sel);
        return (sel == FWD_WB || sel == FWD_MEM) ? sel : FWD_REG;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register bank: clear beats enable, async reset loads
// the same clear value so a flushed stage and a reset stage look alike.
module pipe_reg #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;

    // Bank update: reset/clear to the bubble value, else capture when enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        q_q <= CLR_VAL;
        else if (clr_i) q_q <= CLR_VAL;
        else if (en_i)  q_q <= d_i;
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_ctrl_regs.sv
// PC, IF/ID and ID/EX registers of the 5-stage RV32I core under hazard
// control, plus the EX operand forwarding muxes and perf counters.
module pipe_ctrl_regs
    import pipe_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int               CTRL_W   = CTRL_W_DEF,
    parameter int               CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic              PCSrcE,
    input  logic [XLEN-1:0]   PCTargetE,
    input  logic [31:0]       InstrF,
    output logic [XLEN-1:0]   PCF,
    output logic [31:0]       InstrD,
    output logic [XLEN-1:0]   PCD,
    output logic [XLEN-1:0]   PCPlus4D,
    output logic              ValidD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,
    input  logic [CTRL_W-1:0] CtrlD,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic              ValidE,
    input  logic [1:0]        ForwardAE,
    input  logic [1:0]        ForwardBE,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   ResultW,
    output logic [XLEN-1:0]   SrcAE,
    output logic [XLEN-1:0]   WriteDataE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);
    localparam int DW = 32 + 2 * XLEN + 1;
    localparam int EW = CTRL_W + 15 + 5 * XLEN + 1;
    localparam logic [DW-1:0] D_CLR = {NOP_INSTR, {(2 * XLEN + 1){1'b0}}};

    // ---------------- PC register ----------------
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] pcf_plus4;

    assign pcf_plus4 = pcf_q + PC_INC;

    // Next PC: a redirect is taken even while fetch is stalled
    always_comb begin
        pcf_d = pcf_q;
        if (PCSrcE)       pcf_d = PCTargetE;
        else if (!StallF) pcf_d = pcf_plus4;
    end

    // PC state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pcf_q <= RESET_PC;
        else     pcf_q <= pcf_d;
    end

    assign PCF = pcf_q;

    // ---------------- IF/ID ----------------
    logic [DW-1:0] ifid_d, ifid_q;

    assign ifid_d = {InstrF, pcf_q, pcf_plus4, 1'b1};

    pipe_reg #(.W(DW), .CLR_VAL(D_CLR)) u_ifid (
        .clk   (clk),
        .rst   (rst),
        .en_i  (!StallD),
        .clr_i (FlushD),
        .d_i   (ifid_d),
        .q_o   (ifid_q)
    );

    assign {InstrD, PCD, PCPlus4D, ValidD} = ifid_q;

    // ---------------- ID/EX ----------------
    // No stall on E: a load-use hold is StallD plus a FlushE bubble.
    logic [EW-1:0]   idex_d, idex_q;
    logic [XLEN-1:0] rd1e, rd2e;

    assign idex_d = {CtrlD, Rs1D, Rs2D, RdD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, ValidD};

    pipe_reg #(.W(EW), .CLR_VAL('0)) u_idex (
        .clk   (clk),
        .rst   (rst),
        .en_i  (1'b1),
        .clr_i (FlushE),
        .d_i   (idex_d),
        .q_o   (idex_q)
    );

    assign {CtrlE, Rs1E, Rs2E, RdE, rd1e, rd2e, ImmExtE, PCE, PCPlus4E, ValidE} = idex_q;

    // ---------------- Forwarding ----------------
    // Operand A/B select between register file, WB result and MEM ALU result
    always_comb begin
        SrcAE      = rd1e;
        WriteDataE = rd2e;
        case (fwd_norm(ForwardAE))
            FWD_WB:  SrcAE = ResultW;
            FWD_MEM: SrcAE = ALUResultM;
            default: SrcAE = rd1e;
        endcase
        case (fwd_norm(ForwardBE))
            FWD_WB:  WriteDataE = ResultW;
            FWD_MEM: WriteDataE = ALUResultM;
            default: WriteDataE = rd2e;
        endcase
    end

    // ---------------- Performance counters ----------------
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating increments, each counter independent of the other
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallD && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (FlushE && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // Counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Self-checking bench for pipe_ctrl_regs (4-bit counters so saturation is reachable).
module tb_pipe_ctrl_regs;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, StallD, FlushD, FlushE, PCSrcE;
    logic [31:0] PCTargetE, InstrF;
    logic [31:0] PCF, InstrD, PCD, PCPlus4D;
    logic        ValidD, ValidE;
    logic [31:0] RD1D, RD2D, ImmExtD;
    logic [4:0]  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE;
    logic [11:0] CtrlD, CtrlE;
    logic [31:0] ImmExtE, PCE, PCPlus4E;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUResultM, ResultW, SrcAE, WriteDataE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipe_ctrl_regs #(.XLEN(32), .RESET_PC(32'h0), .CTRL_W(12), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .CtrlD(CtrlD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .CtrlE(CtrlE),
        .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .ValidE(ValidE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUResultM(ALUResultM), .ResultW(ResultW),
        .SrcAE(SrcAE), .WriteDataE(WriteDataE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } d_rec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [11:0] ctrl;
        logic [31:0] imm;
        logic [31:0] pc;
    } e_rec_t;

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } fwd_vec_t;

    d_rec_t   qd[$];
    e_rec_t   qe[$];
    fwd_vec_t fv[6];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " PCF"},       PCF, 32'h0);
        chk({tag, " InstrD"},    InstrD, 32'h13);
        chk({tag, " ValidD"},    ValidD, 1'b0);
        chk({tag, " ValidE"},    ValidE, 1'b0);
        chk({tag, " CtrlE"},     CtrlE, 12'h0);
        chk({tag, " stall_cnt"}, stall_cnt, 4'h0);
        chk({tag, " flush_cnt"}, flush_cnt, 4'h0);
    endtask

    initial begin
        automatic logic [31:0] m_pc = 32'h0, m_pcd = 32'h0, ins = 32'h0, last_ins = 32'h0;
        automatic bit dv = 1'b0, e_exp = 1'b0;
        automatic d_rec_t dr;
        automatic e_rec_t er;

        // Forwarding vectors: RD1E=5, RD2E=6, ALUResultM=7, ResultW=9
        fv[0] = '{2'b10, 2'b00, 32'd7, 32'd6};
        fv[1] = '{2'b01, 2'b01, 32'd9, 32'd9};
        fv[2] = '{2'b00, 2'b10, 32'd5, 32'd7};
        fv[3] = '{2'b11, 2'b11, 32'd5, 32'd6};
        fv[4] = '{2'b10, 2'b01, 32'd7, 32'd9};
        fv[5] = '{2'b00, 2'b00, 32'd5, 32'd6};

        rst = 1'b1;
        {StallF, StallD, FlushD, FlushE, PCSrcE} = '0;
        PCTargetE = '0; InstrF = '0;
        RD1D = '0; RD2D = '0; ImmExtD = '0;
        Rs1D = '0; Rs2D = '0; RdD = '0; CtrlD = '0;
        ForwardAE = '0; ForwardBE = '0; ALUResultM = '0; ResultW = '0;

        #2;
        chk_reset_state("por");
        tick();
        rst = 1'b0;

        // Free run: scoreboard on D and E stage contents
        for (int i = 0; i < 8; i++) begin
            ins = (i < 2) ? 32'h0050_0093 : $urandom;
            InstrF  = ins;
            RdD     = 5'($urandom);
            Rs1D    = 5'($urandom);
            CtrlD   = 12'($urandom) | 12'h1;
            ImmExtD = $urandom;
            qd.push_back('{ins, m_pc});
            e_exp = dv;
            if (dv) qe.push_back('{RdD, CtrlD, ImmExtD, m_pcd});
            tick();
            m_pcd = m_pc;
            m_pc  = m_pc + 32'd4;
            dv    = 1'b1;
            last_ins = ins;
            chk("run PCF", PCF, m_pc);
            dr = qd.pop_front();
            chk("run InstrD",   InstrD, dr.instr);
            chk("run PCD",      PCD, dr.pc);
            chk("run PCPlus4D", PCPlus4D, dr.pc + 32'd4);
            chk("run ValidD",   ValidD, 1'b1);
            chk("run ValidE",   ValidE, e_exp);
            if (qe.size() > 0) begin
                er = qe.pop_front();
                chk("run RdE",    RdE, er.rd);
                chk("run CtrlE",  CtrlE, er.ctrl);
                chk("run ImmExtE", ImmExtE, er.imm);
                chk("run PCE",    PCE, er.pc);
            end
        end

        // Load-use bubble
        StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
        tick();
        chk("lu PCF",       PCF, m_pc);
        chk("lu InstrD",    InstrD, last_ins);
        chk("lu ValidE",    ValidE, 1'b0);
        chk("lu CtrlE",     CtrlE, 12'h0);
        chk("lu RdE",       RdE, 5'h0);
        chk("lu stall_cnt", stall_cnt, 4'd1);
        chk("lu flush_cnt", flush_cnt, 4'd1);
        StallD = 1'b0; FlushE = 1'b0;

        // Taken branch while fetch is stalled
        PCSrcE = 1'b1; PCTargetE = 32'h100; FlushD = 1'b1; FlushE = 1'b1; StallF = 1'b1;
        tick();
        chk("br PCF",       PCF, 32'h100);
        chk("br InstrD",    InstrD, 32'h13);
        chk("br PCD",       PCD, 32'h0);
        chk("br ValidD",    ValidD, 1'b0);
        chk("br ValidE",    ValidE, 1'b0);
        chk("br flush_cnt", flush_cnt, 4'd2);
        PCSrcE = 1'b0; FlushD = 1'b0; FlushE = 1'b0; StallF = 1'b0;
        InstrF = 32'h0020_0113;
        tick();
        chk("br2 PCF",    PCF, 32'h104);
        chk("br2 PCD",    PCD, 32'h100);
        chk("br2 InstrD", InstrD, 32'h0020_0113);
        chk("br2 ValidD", ValidD, 1'b1);
        chk("br2 ValidE", ValidE, 1'b0);

        // FlushD wins over StallD
        StallD = 1'b1; FlushD = 1'b1;
        tick();
        chk("fd ValidD",    ValidD, 1'b0);
        chk("fd InstrD",    InstrD, 32'h13);
        chk("fd stall_cnt", stall_cnt, 4'd2);
        chk("fd PCF",       PCF, 32'h108);
        StallD = 1'b0; FlushD = 1'b0;

        // Forwarding sweep (combinational, no edges)
        RD1D = 32'd5; RD2D = 32'd6;
        tick();
        ALUResultM = 32'd7; ResultW = 32'd9;
        for (int i = 0; i < 6; i++) begin
            ForwardAE = fv[i].fa; ForwardBE = fv[i].fb;
            #1;
            chk($sformatf("fwd%0d SrcAE", i),      SrcAE, fv[i].exp_a);
            chk($sformatf("fwd%0d WriteDataE", i), WriteDataE, fv[i].exp_b);
        end

        // Async reset between edges, mid-stall
        StallD = 1'b1;
        repeat (3) tick();
        chk("pre-rst stall_cnt", stall_cnt, 4'd5);
        #3 rst = 1'b1;
        #1;
        chk_reset_state("async");
        #1 rst = 1'b0; StallD = 1'b0;
        tick();
        chk("post-rst PCF",    PCF, 32'h4);
        chk("post-rst PCD",    PCD, 32'h0);
        chk("post-rst ValidD", ValidD, 1'b1);

        // Saturation, with flushes overlapping the first stalls
        StallD = 1'b1;
        for (int i = 0; i < 20; i++) begin
            FlushE = (i < 3);
            tick();
            chk($sformatf("sat%0d stall_cnt", i), stall_cnt, (i < 15) ? 4'(i + 1) : 4'd15);
        end
        chk("sat flush_cnt", flush_cnt, 4'd3);
        StallD = 1'b0; FlushE = 1'b0;

        // PC wrap-around and plain fetch hold
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        tick();
        chk("wrap PCF0", PCF, 32'hFFFF_FFFC);
        PCSrcE = 1'b0;
        tick();
        chk("wrap PCF1", PCF, 32'h0);
        StallF = 1'b1;
        tick();
        chk("hold PCF", PCF, 32'h0);
        StallF = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
